// File: rtl/pb_go_cond.sv
// pb_go_cond: push-button conditioner placed in front of the tune player.
// It synchronizes and debounces an active-low button and issues one `go`
// pulse for each accepted press. A re-trigger lockout rejects presses while
// a tune started by the previous go is still playing. It also reports the
// debounced level, an optional long-press pulse and a count of accepted
// presses.
// Build option: define PB_LONG_PRESS_EN to build the hold counter and the
// long_press pulse. Without it long_press is tied low.
module pb_go_cond #(
    parameter int FAST_SIM = 1,
    parameter int DB_CYC   = 1048576,
    parameter int LONG_CYC = 33554432,
    parameter int LOCK_CYC = 67108864
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pb_raw,
    output logic       go,
    output logic       long_press,
    output logic       pb_level,
    output logic [7:0] press_cnt
);

    // Timings that are actually in effect (short ones for simulation)
    localparam int DB_A   = (FAST_SIM != 0) ? 16  : DB_CYC;
    localparam int LONG_A = (FAST_SIM != 0) ? 64  : LONG_CYC;
    localparam int LOCK_A = (FAST_SIM != 0) ? 256 : LOCK_CYC;

    localparam int DB_W = (DB_A   > 1) ? $clog2(DB_A)   : 1;
    localparam int LK_W = (LOCK_A > 1) ? $clog2(LOCK_A) : 1;

    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DB_A - 1);
    localparam logic [LK_W-1:0] LOCK_LAST = LK_W'(LOCK_A - 1);

    typedef enum logic [1:0] {
        REL    = 2'd0,
        PRS_DB = 2'd1,
        HELD   = 2'd2,
        REL_DB = 2'd3
    } state_t;

    logic [1:0]      sync_q;
    logic            pressed;
    state_t          state_q, state_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic [LK_W-1:0] lock_cnt_q, lock_cnt_d;
    logic [7:0]      press_cnt_q, press_cnt_d;
    logic            go_q, go_d;
    logic            pb_level_q, pb_level_d;
    logic            enter_held;
    logic            accept;

    // Two-flop synchronizer; both stages idle at 1 (button released)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], pb_raw};
        end
    end

    assign pressed = ~sync_q[1];

    // State register plus all registered outputs and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= REL;
            db_cnt_q    <= '0;
            lock_cnt_q  <= '0;
            press_cnt_q <= '0;
            go_q        <= 1'b0;
            pb_level_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            lock_cnt_q  <= lock_cnt_d;
            press_cnt_q <= press_cnt_d;
            go_q        <= go_d;
            pb_level_q  <= pb_level_d;
        end
    end

    // Next-state logic: debounce in both directions with one shared counter
    always_comb begin
        state_d  = state_q;
        db_cnt_d = db_cnt_q;
        case (state_q)
            REL: begin
                if (pressed) begin
                    state_d  = PRS_DB;
                    db_cnt_d = '0;
                end
            end
            PRS_DB: begin
                if (!pressed) begin
                    state_d = REL;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d = HELD;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
            HELD: begin
                if (!pressed) begin
                    state_d  = REL_DB;
                    db_cnt_d = '0;
                end
            end
            REL_DB: begin
                if (pressed) begin
                    state_d = HELD;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d = REL;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
            default: begin
                state_d  = REL;
                db_cnt_d = '0;
            end
        endcase
    end

    // A press completes only on the PRS_DB->HELD edge, never on a bounce back
    assign enter_held = (state_q == PRS_DB) && (state_d == HELD);
    assign accept     = enter_held && (lock_cnt_q == '0);

    // Output logic: go pulse, press count, lockout timer, debounced level
    always_comb begin
        go_d        = accept;
        press_cnt_d = press_cnt_q + {7'd0, accept};
        lock_cnt_d  = lock_cnt_q;
        if (accept) begin
            lock_cnt_d = LOCK_LAST;
        end else if (lock_cnt_q != '0) begin
            lock_cnt_d = lock_cnt_q - LK_W'(1);
        end
        // Level rises with the press; it drops one clock after REL is
        // re-entered, which accounts for the HELD->REL_DB hop on release.
        pb_level_d = pb_level_q;
        if (enter_held) begin
            pb_level_d = 1'b1;
        end else if (state_q == REL) begin
            pb_level_d = 1'b0;
        end
    end

    assign go        = go_q;
    assign pb_level  = pb_level_q;
    assign press_cnt = press_cnt_q;

`ifdef PB_LONG_PRESS_EN
    localparam int LG_W = (LONG_A > 1) ? $clog2(LONG_A) : 1;
    localparam logic [LG_W-1:0] LONG_LAST = LG_W'(LONG_A - 1);

    logic [LG_W-1:0] hold_cnt_q, hold_cnt_d;
    logic            long_press_q, long_press_d;

    // Hold timer register and its one-shot long-press pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q   <= '0;
            long_press_q <= 1'b0;
        end else begin
            hold_cnt_q   <= hold_cnt_d;
            long_press_q <= long_press_d;
        end
    end

    // Count while held (including release bounces); pulse once on saturation
    always_comb begin
        hold_cnt_d   = hold_cnt_q;
        long_press_d = 1'b0;
        if (enter_held) begin
            hold_cnt_d = '0;
        end else if ((state_q == REL_DB) && (state_d == REL)) begin
            hold_cnt_d = '0;
        end else if (((state_q == HELD) || (state_q == REL_DB)) &&
                     (hold_cnt_q != LONG_LAST)) begin
            hold_cnt_d   = hold_cnt_q + LG_W'(1);
            long_press_d = ((hold_cnt_q + LG_W'(1)) == LONG_LAST);
        end
    end

    assign long_press = long_press_q;
`else
    assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_pb_go_cond.sv
// Scoreboard bench for pb_go_cond (FAST_SIM timings). Stimulus pushes the
// expected go / long_press / level-change events into queues; a monitor on
// the falling edge pops and compares whenever the DUT shows one.
module tb_pb_go_cond;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pb_raw;
    logic       go;
    logic       long_press;
    logic       pb_level;
    logic [7:0] press_cnt;

    pb_go_cond #(
        .FAST_SIM(1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pb_raw    (pb_raw),
        .go        (go),
        .long_press(long_press),
        .pb_level  (pb_level),
        .press_cnt (press_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int val;
    } ev_t;

    ev_t  go_q[$];
    ev_t  long_q[$];
    ev_t  lvl_q[$];
    ev_t  mon_e;
    ev_t  end_e;
    int   checks = 0;
    int   errors = 0;
    int   go_seen = 0;
    int   long_seen = 0;
    int   long_exp = 0;
    logic prev_level = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void exp_go(input int c, input int cnt);
        ev_t e;
        e.cyc = c;
        e.val = cnt;
        go_q.push_back(e);
    endfunction

    function automatic void exp_lvl(input int c, input int v);
        ev_t e;
        e.cyc = c;
        e.val = v;
        lvl_q.push_back(e);
    endfunction

    function automatic void exp_long(input int c);
        ev_t e;
        e.cyc = c;
        e.val = 1;
        long_q.push_back(e);
    endfunction

    // Monitor: compare every output event against the scoreboard
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (go === 1'b1) begin
                go_seen++;
                if (go_q.size() == 0) begin
                    chk("go_unexpected", 1, 0);
                end else begin
                    mon_e = go_q.pop_front();
                    chk("go_cycle", cyc, mon_e.cyc);
                    chk("go_press_cnt", int'(press_cnt), mon_e.val);
                    chk("go_level", int'(pb_level), 1);
                end
            end
            if (long_press === 1'b1) begin
                long_seen++;
                if (long_q.size() == 0) begin
                    chk("long_unexpected", 1, 0);
                end else begin
                    mon_e = long_q.pop_front();
                    chk("long_cycle", cyc, mon_e.cyc);
                end
            end
            if (pb_level !== prev_level) begin
                if (lvl_q.size() == 0) begin
                    chk("level_unexpected", int'(pb_level), int'(prev_level));
                end else begin
                    mon_e = lvl_q.pop_front();
                    chk("level_cycle", cyc, mon_e.cyc);
                    chk("level_value", int'(pb_level), mon_e.val);
                end
            end
        end
        prev_level = pb_level;
    end

    // Advance to just after the posedge that brings cyc to t
    task automatic at(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    int b;
    int p2;
    int p3;

    initial begin
        rst_n  = 1'b0;
        pb_raw = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_go", int'(go), 0);
        chk("reset_long", int'(long_press), 0);
        chk("reset_level", int'(pb_level), 0);
        chk("reset_cnt", int'(press_cnt), 0);
        rst_n = 1'b1;
        at(cyc + 5);

        // Clean press, held 60 clocks
        b = cyc;
        pb_raw = 1'b0;
        exp_go(b + 19, 1);
        exp_lvl(b + 19, 1);
        at(b + 60);
        pb_raw = 1'b1;
        exp_lvl(b + 80, 0);
        at(b + 400);

        // Bouncy press: toggles every 5 clocks for 40 clocks, then settles
        b = cyc;
        for (int i = 0; i < 8; i++) begin
            pb_raw = i[0];
            at(b + 5 * (i + 1));
        end
        pb_raw = 1'b0;
        exp_go(b + 59, 2);
        exp_lvl(b + 59, 1);
        at(b + 100);
        pb_raw = 1'b1;
        exp_lvl(b + 120, 0);
        at(b + 450);

        // Lockout: re-press completing 100 clocks after go is rejected,
        // one completing 300 clocks after go is accepted
        b = cyc;
        pb_raw = 1'b0;
        exp_go(b + 19, 3);
        exp_lvl(b + 19, 1);
        at(b + 30);
        pb_raw = 1'b1;
        exp_lvl(b + 50, 0);
        at(b + 100);
        pb_raw = 1'b0;
        exp_lvl(b + 119, 1);
        at(b + 130);
        pb_raw = 1'b1;
        exp_lvl(b + 150, 0);
        at(b + 300);
        pb_raw = 1'b0;
        exp_go(b + 319, 4);
        exp_lvl(b + 319, 1);
        at(b + 330);
        pb_raw = 1'b1;
        exp_lvl(b + 350, 0);
        at(b + 650);

        // Boundary: completion while lock_cnt==1 is rejected
        b = cyc;
        pb_raw = 1'b0;
        exp_go(b + 19, 5);
        exp_lvl(b + 19, 1);
        at(b + 30);
        pb_raw = 1'b1;
        exp_lvl(b + 50, 0);
        at(b + 255);
        pb_raw = 1'b0;
        exp_lvl(b + 274, 1);
        at(b + 285);
        pb_raw = 1'b1;
        exp_lvl(b + 305, 0);
        at(b + 600);

        // Boundary: completion at lock_cnt==0 is accepted
        b = cyc;
        pb_raw = 1'b0;
        exp_go(b + 19, 6);
        exp_lvl(b + 19, 1);
        at(b + 30);
        pb_raw = 1'b1;
        exp_lvl(b + 50, 0);
        at(b + 256);
        pb_raw = 1'b0;
        exp_go(b + 275, 7);
        exp_lvl(b + 275, 1);
        at(b + 285);
        pb_raw = 1'b1;
        exp_lvl(b + 305, 0);
        at(b + 600);

        // Long press: held 200 clocks
        b = cyc;
        pb_raw = 1'b0;
        exp_go(b + 19, 8);
        exp_lvl(b + 19, 1);
`ifdef PB_LONG_PRESS_EN
        exp_long(b + 82);
        long_exp = 1;
`endif
        at(b + 200);
        pb_raw = 1'b1;
        exp_lvl(b + 220, 0);
        at(b + 500);
        chk("long_count", long_seen, long_exp);

        // Reset during PRS_DB, release with button still held
        b = cyc;
        pb_raw = 1'b0;
        at(b + 10);
        rst_n = 1'b0;
        #1;
        chk("rst_prs_go", int'(go), 0);
        chk("rst_prs_level", int'(pb_level), 0);
        chk("rst_prs_cnt", int'(press_cnt), 0);
        at(b + 15);
        rst_n = 1'b1;
        p2 = cyc;
        exp_go(p2 + 19, 1);
        exp_lvl(p2 + 19, 1);

        // Reset while HELD, release with button still held
        at(p2 + 30);
        rst_n = 1'b0;
        #1;
        chk("rst_held_go", int'(go), 0);
        chk("rst_held_long", int'(long_press), 0);
        chk("rst_held_level", int'(pb_level), 0);
        chk("rst_held_cnt", int'(press_cnt), 0);
        at(p2 + 35);
        rst_n = 1'b1;
        p3 = cyc;
        exp_go(p3 + 19, 1);
        exp_lvl(p3 + 19, 1);
        at(p3 + 40);
        pb_raw = 1'b1;
        exp_lvl(p3 + 60, 0);
        at(p3 + 400);

        // Wrap: 256 accepted presses from a fresh reset
        rst_n = 1'b0;
        at(cyc + 2);
        rst_n = 1'b1;
        at(cyc + 5);
        go_seen = 0;
        for (int k = 1; k <= 256; k++) begin
            b = cyc;
            pb_raw = 1'b0;
            exp_go(b + 19, k % 256);
            exp_lvl(b + 19, 1);
            at(b + 21);
            pb_raw = 1'b1;
            exp_lvl(b + 41, 0);
            at(b + 260);
        end
        at(cyc + 30);
        chk("wrap_go_count", go_seen, 256);
        chk("wrap_press_cnt", int'(press_cnt), 0);
        chk("long_total", long_seen, long_exp);

        // Every expected event must have been consumed
        chk("go_queue_left", go_q.size(), 0);
        chk("long_queue_left", long_q.size(), 0);
        chk("level_queue_left", lvl_q.size(), 0);
        while (go_q.size() != 0) begin
            end_e = go_q.pop_front();
            $display("FAIL go_missing: got no pulse, expected one at cycle %0d", end_e.cyc);
        end
        while (long_q.size() != 0) begin
            end_e = long_q.pop_front();
            $display("FAIL long_missing: got no pulse, expected one at cycle %0d", end_e.cyc);
        end
        while (lvl_q.size() != 0) begin
            end_e = lvl_q.pop_front();
            $display("FAIL level_missing: got no change, expected %0d at cycle %0d", end_e.val, end_e.cyc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
